// File: rtl/lsu_align.sv
// Load/store alignment between the MEM pipeline register and dmem; optional split of misaligned accesses (LSU_MISALIGN_SPLIT_EN).
// Latency: dmem_* combinational from request/state; load_data/load_valid one cycle after an aligned access, after the second access when split.
// Backpressure: stall=1 during the first half of a split access, so the pipeline holds its request for one extra cycle; otherwise never stalls.
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned halfword/word accesses into two
// word accesses (IDLE -> SPLIT2). Without it, misaligned requests are rejected with a misalign_err pulse.

module lsu_align #(
   parameter int XLEN        = 32,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            req_store,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            stall,
   output logic            load_valid,
   output logic [XLEN-1:0] load_data,
   output logic            misalign_err,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_a,
   output logic [XLEN-1:0] dmem_wd,
   output logic [3:0]      dmem_byteen,
   input  logic [XLEN-1:0] dmem_rd
);

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
   typedef enum logic {IDLE = 1'b0, SPLIT2 = 1'b1} state_t;
`else
   localparam bit SPLIT_EN = 1'b0;
   typedef enum logic {IDLE = 1'b0} state_t;
`endif

   // Byte-lane mask for an access size, right-justified (size 11 behaves as word).
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Number of bytes moved by an access size.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Sign/zero extension of a right-justified load value to 32 bits.
   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                          input logic uns);
      logic fill;
      case (size)
         2'b00: begin
            fill = ~uns & raw[7];
            return {{24{fill}}, raw[7:0]};
         end
         2'b01: begin
            fill = ~uns & raw[15];
            return {{16{fill}}, raw[15:0]};
         end
         default: return raw;
      endcase
   endfunction

   state_t     state;
   state_t     state_nxt;
   logic       in_split;
   logic [1:0] req_off;
   logic       req_mis;

`ifdef LSU_MISALIGN_SPLIT_EN
   // Request captured at the first half of a split so the second half does not depend on the bus.
   logic        h_store;
   logic [1:0]  h_size;
   logic        h_unsigned;
   logic [1:0]  h_off;
   logic [29:0] h_word;
   logic [31:0] h_wdata;
   logic [31:0] hold_rd;

   assign in_split = (state == SPLIT2);
`else
   assign in_split = (state != IDLE);
`endif

   // Effective byte offset and misalignment of the incoming request.
   always_comb begin
      req_off = req_addr[1:0];
      if (!ALIGN_CHECK && req_size != 2'b00) begin
         req_off = 2'b00;
      end
      req_mis = ({1'b0, req_off} + size_bytes(req_size)) > 3'd4;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a misaligned request in IDLE spends one extra cycle in SPLIT2.
   always_comb begin
      state_nxt = IDLE;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (!in_split && req_valid && req_mis) begin
         state_nxt = SPLIT2;
      end
`endif
   end

   // dmem access and stall, combinational from the request (IDLE) or the held request (SPLIT2).
   always_comb begin
      stall       = 1'b0;
      dmem_we     = 1'b0;
      dmem_a      = '0;
      dmem_wd     = '0;
      dmem_byteen = 4'b0000;
      if (!reset) begin
         if (in_split) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            dmem_a      = {h_word + 30'd1, 2'b00};
            dmem_we     = h_store;
            dmem_byteen = h_store ? (size_mask(h_size) >> (3'd4 - {1'b0, h_off})) : 4'b0000;
            dmem_wd     = h_wdata >> (6'd32 - {1'b0, h_off, 3'b000});
`endif
         end else if (req_valid) begin
            dmem_a = {req_addr[31:2], 2'b00};
            if (!req_mis || SPLIT_EN) begin
               dmem_we     = req_store;
               dmem_byteen = req_store ? (size_mask(req_size) << req_off) : 4'b0000;
               dmem_wd     = req_wdata << {req_off, 3'b000};
            end
            stall = req_mis && SPLIT_EN;
         end
      end
   end

   // Load return path, misalignment error pulse and split capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_valid   <= 1'b0;
         load_data    <= '0;
         misalign_err <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         h_store      <= 1'b0;
         h_size       <= 2'b00;
         h_unsigned   <= 1'b0;
         h_off        <= 2'b00;
         h_word       <= '0;
         h_wdata      <= '0;
         hold_rd      <= '0;
`endif
      end else begin
         load_valid   <= 1'b0;
         misalign_err <= 1'b0;
         if (in_split) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            // Low bytes come from the first word, the rest from lane 0 upward of the second.
            if (!h_store) begin
               load_valid <= 1'b1;
               load_data  <= extend(hold_rd | (dmem_rd << (6'd32 - {1'b0, h_off, 3'b000})),
                                    h_size, h_unsigned);
            end
`endif
         end else if (req_valid) begin
            if (!req_mis) begin
               if (!req_store) begin
                  load_valid <= 1'b1;
                  load_data  <= extend(dmem_rd >> {req_off, 3'b000}, req_size, req_unsigned);
               end
            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
               h_store    <= req_store;
               h_size     <= req_size;
               h_unsigned <= req_unsigned;
               h_off      <= req_off;
               h_word     <= req_addr[31:2];
               h_wdata    <= req_wdata;
               hold_rd    <= dmem_rd >> {req_off, 3'b000};
`else
               misalign_err <= 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed vector table, hand-written split/reject sequences,
// and randomized accesses checked against a byte-addressed memory model.
// A 64-byte dmem model answers dmem reads and applies byte-enabled writes.

module tb_lsu_align;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_store, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        stall, load_valid, misalign_err, dmem_we;
   logic [31:0] load_data, dmem_a, dmem_wd, dmem_rd;
   logic [3:0]  dmem_byteen;

   int total = 0;
   int bad   = 0;

   logic [31:0] dmem [16];
   logic [7:0]  refm [64];

   always #5 clk = ~clk;

   lsu_align dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
      .load_data(load_data), .misalign_err(misalign_err), .dmem_we(dmem_we),
      .dmem_a(dmem_a), .dmem_wd(dmem_wd), .dmem_byteen(dmem_byteen), .dmem_rd(dmem_rd)
   );

   // Environment memory: combinational read, byte-enabled write, cleared by reset.
   assign dmem_rd = dmem[dmem_a[5:2]];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) dmem[i] <= '0;
      end else if (dmem_we) begin
         for (int i = 0; i < 4; i++)
            if (dmem_byteen[i]) dmem[dmem_a[5:2]][8*i +: 8] <= dmem_wd[8*i +: 8];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // ---------------- reference model (byte memory, spec arithmetic) ----------------
   function automatic int nb(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
   endfunction

   task automatic ref_clear();
      for (int i = 0; i < 64; i++) refm[i] = 8'h00;
   endtask

   task automatic ref_store(input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] wd);
      for (int i = 0; i < nb(sz); i++) refm[6'(ad + 32'(i))] = wd[8*i +: 8];
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] ad, input logic [1:0] sz,
                                            input logic un);
      logic [31:0] r;
      int n;
      r = '0;
      n = nb(sz);
      for (int i = 0; i < n; i++) r[8*i +: 8] = refm[6'(ad + 32'(i))];
      if (!un && n < 4 && r[8*n-1])
         for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   task automatic drive(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd);
      req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
      req_addr = ad; req_wdata = wd;
   endtask

   task automatic idle_check(input string nm);
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk1({nm, "_lv_pulse"}, load_valid, 1'b0);
      chk1({nm, "_err_pulse"}, misalign_err, 1'b0);
   endtask

   // ---------------- model-checked access (any alignment) ----------------
   task automatic rand_access(input logic st, input logic [1:0] sz, input logic un,
                              input logic [31:0] ad, input logic [31:0] wd);
      int n, off;
      bit mis, rej;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      n = nb(sz); off = int'(ad[1:0]); mis = (off + n) > 4; rej = mis && !SPLIT;
      @(negedge clk); drive(st, sz, un, ad, wd); #1;
      chk1("r_stall1", stall, mis && SPLIT);
      chk("r_a1", dmem_a, {ad[31:2], 2'b00});
      if (rej) begin
         chk1("r_we_rej", dmem_we, 1'b0);
         chk("r_be_rej", 32'(dmem_byteen), 32'h0);
      end else begin
         ebe = '0; ewd = '0;
         for (int i = off; i < 4; i++) begin
            if (st && i < off + n) ebe[i] = 1'b1;
            ewd[8*i +: 8] = wd[8*(i-off) +: 8];
         end
         chk1("r_we1", dmem_we, st);
         chk("r_be1", 32'(dmem_byteen), 32'(ebe));
         chk("r_wd1", dmem_wd, ewd);
      end
      @(posedge clk); #1;
      if (mis && SPLIT) begin
         ebe = '0; ewd = '0;
         for (int i = 0; i < off; i++) begin
            if (st && i < off + n - 4) ebe[i] = 1'b1;
            ewd[8*i +: 8] = wd[8*(i+4-off) +: 8];
         end
         chk1("r_lv_mid", load_valid, 1'b0);
         chk1("r_stall2", stall, 1'b0);
         chk("r_a2", dmem_a, {ad[31:2], 2'b00} + 32'd4);
         chk1("r_we2", dmem_we, st);
         chk("r_be2", 32'(dmem_byteen), 32'(ebe));
         chk("r_wd2", dmem_wd, ewd);
         @(posedge clk); #1;
      end
      chk1("r_err", misalign_err, rej);
      chk1("r_lv", load_valid, !st && !rej);
      if (!st && !rej) chk("r_ld", load_data, ref_load(ad, sz, un));
      if (st && !rej) ref_store(ad, sz, wd);
      idle_check("r");
   endtask

   // ---------------- directed vector table (aligned accesses) ----------------
   typedef struct {
      logic        st;
      logic [1:0]  sz;
      logic        un;
      logic [31:0] ad;
      logic [31:0] wd;
      logic [31:0] e_a;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_ld;
   } vec_t;

   vec_t tbl [18];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF, 32'h04, 4'b1111, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h04, 4'b0000, 32'h0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h06, 32'hAA, 32'h04, 4'b0100, 32'h00AA0000, 32'h0};
      tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 32'h04, 4'b0000, 32'h0, 32'hFFFFFFAA};
      tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h06, 32'h0, 32'h04, 4'b0000, 32'h0, 32'h000000AA};
      tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h04, 4'b0000, 32'h0, 32'hDEAABEEF};
      tbl[6]  = '{1'b1, 2'b10, 1'b0, 32'h04, 32'h8001BEEF, 32'h04, 4'b1111, 32'h8001BEEF, 32'h0};
      tbl[7]  = '{1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'h04, 4'b0000, 32'h0, 32'hFFFFBEEF};
      tbl[8]  = '{1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 32'h04, 4'b0000, 32'h0, 32'h00008001};
      tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 32'h04, 4'b0000, 32'h0, 32'hFFFF8001};
      tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h0A, 32'hFFFF1234, 32'h08, 4'b1100, 32'h12340000, 32'h0};
      tbl[11] = '{1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 32'h08, 4'b0000, 32'h0, 32'h00000012};
      tbl[12] = '{1'b0, 2'b00, 1'b0, 32'h0A, 32'h0, 32'h08, 4'b0000, 32'h0, 32'h00000034};
      tbl[13] = '{1'b1, 2'b00, 1'b0, 32'h03, 32'h1234567F, 32'h00, 4'b1000, 32'h7F000000, 32'h0};
      tbl[14] = '{1'b0, 2'b10, 1'b1, 32'h00, 32'h0, 32'h00, 4'b0000, 32'h0, 32'h7F000000};
      tbl[15] = '{1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 32'h08, 4'b0000, 32'h0, 32'h12340000};
      tbl[16] = '{1'b1, 2'b10, 1'b0, 32'hFFFFFFF0, 32'hCAFEF00D, 32'hFFFFFFF0, 4'b1111,
                  32'hCAFEF00D, 32'h0};
      tbl[17] = '{1'b0, 2'b01, 1'b1, 32'hFFFFFFF2, 32'h0, 32'hFFFFFFF0, 4'b0000, 32'h0,
                  32'h0000CAFE};

      // Reset state
      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      ref_clear();
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_lv", load_valid, 1'b0);
      chk("rst_ld", load_data, 32'h0);
      chk1("rst_err", misalign_err, 1'b0);
      chk1("rst_we", dmem_we, 1'b0);
      chk("rst_be", 32'(dmem_byteen), 32'h0);
      chk("rst_a", dmem_a, 32'h0);
      chk("rst_wd", dmem_wd, 32'h0);
      @(negedge clk); reset = 1'b0;

      // Directed table
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         drive(tbl[k].st, tbl[k].sz, tbl[k].un, tbl[k].ad, tbl[k].wd);
         #1;
         chk($sformatf("t%0d_a", k), dmem_a, tbl[k].e_a);
         chk($sformatf("t%0d_be", k), 32'(dmem_byteen), 32'(tbl[k].e_be));
         chk($sformatf("t%0d_wd", k), dmem_wd, tbl[k].e_wd);
         chk1($sformatf("t%0d_we", k), dmem_we, tbl[k].st);
         chk1($sformatf("t%0d_stall", k), stall, 1'b0);
         @(posedge clk); #1;
         chk1($sformatf("t%0d_lv", k), load_valid, !tbl[k].st);
         if (!tbl[k].st) chk($sformatf("t%0d_ld", k), load_data, tbl[k].e_ld);
         if (tbl[k].st) ref_store(tbl[k].ad, tbl[k].sz, tbl[k].wd);
         idle_check($sformatf("t%0d", k));
      end

      // No access when req_valid is low
      @(negedge clk); req_valid = 1'b0; req_store = 1'b1; req_size = 2'b10;
      #1;
      chk1("novld_we", dmem_we, 1'b0);
      chk("novld_be", 32'(dmem_byteen), 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
      // Split word store @0x0A, then split load of the same word
      @(negedge clk); drive(1'b1, 2'b10, 1'b0, 32'h0A, 32'h11223344); #1;
      chk("sp_a1", dmem_a, 32'h08);
      chk("sp_be1", 32'(dmem_byteen), 32'hC);
      chk("sp_wd1", dmem_wd, 32'h33440000);
      chk1("sp_stall1", stall, 1'b1);
      @(posedge clk); #1;
      chk("sp_a2", dmem_a, 32'h0C);
      chk("sp_be2", 32'(dmem_byteen), 32'h3);
      chk("sp_wd2", dmem_wd, 32'h00001122);
      chk1("sp_stall2", stall, 1'b0);
      @(posedge clk); #1;
      chk1("sp_st_lv", load_valid, 1'b0);
      ref_store(32'h0A, 2'b10, 32'h11223344);
      idle_check("sp_st");
      @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h0A, 32'h0); #1;
      chk1("spl_stall1", stall, 1'b1);
      @(posedge clk); #1;
      chk1("spl_lv_mid", load_valid, 1'b0);
      @(posedge clk); #1;
      chk1("spl_lv", load_valid, 1'b1);
      chk("spl_ld", load_data, 32'h11223344);
      idle_check("spl");

      // Halfword store across the top of the address space wraps to word 0
      @(negedge clk); drive(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0000ABCD); #1;
      chk("wrap_a1", dmem_a, 32'hFFFFFFFC);
      chk("wrap_be1", 32'(dmem_byteen), 32'h8);
      chk("wrap_wd1", dmem_wd, 32'hCD000000);
      @(posedge clk); #1;
      chk("wrap_a2", dmem_a, 32'h0);
      chk("wrap_be2", 32'(dmem_byteen), 32'h1);
      chk("wrap_wd2", dmem_wd, 32'h000000AB);
      @(posedge clk); #1;
      ref_store(32'hFFFFFFFF, 2'b01, 32'h0000ABCD);
      idle_check("wrap");

      // Reset while in SPLIT2: no second write, no load_valid, back to IDLE
      for (int s = 1; s >= 0; s--) begin
         @(negedge clk); drive(1'(s), 2'b10, 1'b0, 32'h0E, 32'h55667788); #1;
         chk1("rs_stall1", stall, 1'b1);
         @(posedge clk); #1;
         reset = 1'b1; #1;
         chk1("rs_we", dmem_we, 1'b0);
         chk("rs_be", 32'(dmem_byteen), 32'h0);
         chk1("rs_stall", stall, 1'b0);
         @(posedge clk); #1;
         chk1("rs_lv", load_valid, 1'b0);
         reset = 1'b0; req_valid = 1'b0;
         ref_clear();
         @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0); #1;
         chk1("rs_idle_stall", stall, 1'b0);
         @(posedge clk); #1;
         chk1("rs_idle_lv", load_valid, 1'b1);
         chk("rs_idle_ld", load_data, 32'h0);
         idle_check("rs");
      end
`else
      // Misaligned requests are rejected: no write, error pulse next cycle, no load
      for (int m = 0; m < 3; m++) begin
         @(negedge clk);
         case (m)
            0: drive(1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
            1: drive(1'b1, 2'b10, 1'b0, 32'h0A, 32'hFFFFFFFF);
            default: drive(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000FFFF);
         endcase
         #1;
         chk1($sformatf("rej%0d_we", m), dmem_we, 1'b0);
         chk($sformatf("rej%0d_be", m), 32'(dmem_byteen), 32'h0);
         chk1($sformatf("rej%0d_stall", m), stall, 1'b0);
         @(posedge clk); #1;
         chk1($sformatf("rej%0d_err", m), misalign_err, 1'b1);
         chk1($sformatf("rej%0d_lv", m), load_valid, 1'b0);
         idle_check($sformatf("rej%0d", m));
      end
      // Memory untouched by the rejected stores
      @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h08, 32'h0); #1;
      @(posedge clk); #1;
      chk("rej_mem8", load_data, 32'h12340000);
      idle_check("rej_m8");
      @(negedge clk); drive(1'b0, 2'b10, 1'b0, 32'h00, 32'h0); #1;
      @(posedge clk); #1;
      chk("rej_mem0", load_data, 32'h7F000000);
      idle_check("rej_m0");
`endif

      // Randomized accesses against the byte-memory model
      for (int r = 0; r < 400; r++) begin
         rand_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
